// File: rtl/arbitrary_sequence_checker.sv
// arbitrary_sequence_checker
//   Link-integrity monitor for the repeating 3-bit sequence 0,1,2,3,6,5,7.
//   The checker hunts for a 0, then locks and compares every valid sample
//   against the expected table entry. Each sample is decoded to its position
//   in the table. A mismatch while locked is flagged and counted.
//   MISS_LIMIT consecutive misses drop the lock.
//   Optional feature macro: ARB_SEQ_PERIOD_CNT_EN adds a saturating
//   period_count output that counts completed periods.
module arbitrary_sequence_checker #(
  parameter int ERR_CNT_W  = 8,
  parameter int MISS_LIMIT = 3
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [2:0]           seq_in,
  input  logic                 seq_valid,
  input  logic                 clr_err,
  output logic                 locked,
  output logic [2:0]           seq_idx,
  output logic                 err_pulse,
  output logic                 illegal_pulse,
  output logic                 wrap_pulse,
`ifdef ARB_SEQ_PERIOD_CNT_EN
  output logic [15:0]          period_count,
`endif
  output logic [ERR_CNT_W-1:0] err_count
);

  // Wide enough to hold 0..MISS_LIMIT-1, never narrower than one bit
  localparam int MISS_W = (MISS_LIMIT > 1) ? $clog2(MISS_LIMIT) : 1;
  localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MISS_LIMIT - 1);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            exp_idx_q, exp_idx_d;
  logic [MISS_W-1:0]     miss_cnt_q, miss_cnt_d;
  logic [2:0]            seq_idx_q, seq_idx_d;
  logic                  err_pulse_q, err_pulse_d;
  logic                  illegal_q, illegal_d;
  logic                  wrap_q, wrap_d;
  logic [ERR_CNT_W-1:0]  err_count_q, err_count_d;
  logic                  err_inc;
  logic [2:0]            exp_idx_adv;

  // Table entry expected at a given sequence position
  function automatic logic [2:0] table_val(input logic [2:0] idx);
    case (idx)
      3'd0:    table_val = 3'd0;
      3'd1:    table_val = 3'd1;
      3'd2:    table_val = 3'd2;
      3'd3:    table_val = 3'd3;
      3'd4:    table_val = 3'd6;
      3'd5:    table_val = 3'd5;
      default: table_val = 3'd7;
    endcase
  endfunction

  // Position of a received value in the table; 4 is illegal and maps to 7
  function automatic logic [2:0] value_pos(input logic [2:0] val);
    case (val)
      3'd0:    value_pos = 3'd0;
      3'd1:    value_pos = 3'd1;
      3'd2:    value_pos = 3'd2;
      3'd3:    value_pos = 3'd3;
      3'd6:    value_pos = 3'd4;
      3'd5:    value_pos = 3'd5;
      3'd7:    value_pos = 3'd6;
      default: value_pos = 3'd7;
    endcase
  endfunction

  // Expected position after the current one, wrapping 6 -> 0
  assign exp_idx_adv = (exp_idx_q == 3'd6) ? 3'd0 : exp_idx_q + 3'd1;

  // Next-state and registered-output decode
  always_comb begin
    state_d     = state_q;
    exp_idx_d   = exp_idx_q;
    miss_cnt_d  = miss_cnt_q;
    seq_idx_d   = seq_idx_q;
    err_pulse_d = 1'b0;
    illegal_d   = 1'b0;
    wrap_d      = 1'b0;
    err_inc     = 1'b0;

    if (seq_valid) begin
      seq_idx_d = value_pos(seq_in);
      illegal_d = (seq_in == 3'd4);
      case (state_q)
        HUNT: begin
          if (seq_in == 3'd0) begin
            state_d    = LOCK;
            exp_idx_d  = 3'd1;
            miss_cnt_d = '0;
          end
        end
        LOCK: begin
          exp_idx_d = exp_idx_adv;
          if (seq_in == table_val(exp_idx_q)) begin
            miss_cnt_d = '0;
            wrap_d     = (exp_idx_q == 3'd6);
          end else begin
            // Corrupted sample: flag it but keep stepping through the table
            err_pulse_d = 1'b1;
            err_inc     = 1'b1;
            if (miss_cnt_q == MISS_LAST) begin
              state_d    = HUNT;
              miss_cnt_d = '0;
            end else begin
              miss_cnt_d = miss_cnt_q + MISS_W'(1);
            end
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  // Saturating error counter; a clear overrides a same-cycle increment
  always_comb begin
    err_count_d = err_count_q;
    if (clr_err) begin
      err_count_d = '0;
    end else if (err_inc && (err_count_q != {ERR_CNT_W{1'b1}})) begin
      err_count_d = err_count_q + ERR_CNT_W'(1);
    end
  end

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HUNT;
      exp_idx_q   <= 3'd0;
      miss_cnt_q  <= '0;
      seq_idx_q   <= 3'd0;
      err_pulse_q <= 1'b0;
      illegal_q   <= 1'b0;
      wrap_q      <= 1'b0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      exp_idx_q   <= exp_idx_d;
      miss_cnt_q  <= miss_cnt_d;
      seq_idx_q   <= seq_idx_d;
      err_pulse_q <= err_pulse_d;
      illegal_q   <= illegal_d;
      wrap_q      <= wrap_d;
      err_count_q <= err_count_d;
    end
  end

  assign locked        = (state_q == LOCK);
  assign seq_idx       = seq_idx_q;
  assign err_pulse     = err_pulse_q;
  assign illegal_pulse = illegal_q;
  assign wrap_pulse    = wrap_q;
  assign err_count     = err_count_q;

`ifdef ARB_SEQ_PERIOD_CNT_EN
  logic [15:0] period_q, period_d;

  // Completed-period counter; clear overrides a same-cycle increment
  always_comb begin
    period_d = period_q;
    if (clr_err) begin
      period_d = 16'd0;
    end else if (wrap_d && (period_q != 16'hFFFF)) begin
      period_d = period_q + 16'd1;
    end
  end

  // Period counter register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= 16'd0;
    end else begin
      period_q <= period_d;
    end
  end

  assign period_count = period_q;
`endif

endmodule

// File: tb/tb_arbitrary_sequence_checker.sv
// Self-checking bench for arbitrary_sequence_checker. Two instances share
// the stimulus: one with default parameters and one with ERR_CNT_W=2,
// MISS_LIMIT=8. Both are compared against a table-driven reference model.
module tb_arbitrary_sequence_checker;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [2:0] seq_in = 3'd0;
  logic       seq_valid = 1'b0;
  logic       clr_err = 1'b0;

  logic       lk1, ep1, ip1, wp1;
  logic [2:0] idx1;
  logic [7:0] ec1;
  logic       lk2, ep2, ip2, wp2;
  logic [2:0] idx2;
  logic [1:0] ec2;
`ifdef ARB_SEQ_PERIOD_CNT_EN
  logic [15:0] pc1, pc2;
`endif

  always #5 clock = ~clock;

  arbitrary_sequence_checker dut1 (
    .clock(clock), .reset_n(reset_n), .seq_in(seq_in), .seq_valid(seq_valid),
    .clr_err(clr_err), .locked(lk1), .seq_idx(idx1), .err_pulse(ep1),
    .illegal_pulse(ip1), .wrap_pulse(wp1),
`ifdef ARB_SEQ_PERIOD_CNT_EN
    .period_count(pc1),
`endif
    .err_count(ec1)
  );

  arbitrary_sequence_checker #(.ERR_CNT_W(2), .MISS_LIMIT(8)) dut2 (
    .clock(clock), .reset_n(reset_n), .seq_in(seq_in), .seq_valid(seq_valid),
    .clr_err(clr_err), .locked(lk2), .seq_idx(idx2), .err_pulse(ep2),
    .illegal_pulse(ip2), .wrap_pulse(wp2),
`ifdef ARB_SEQ_PERIOD_CNT_EN
    .period_count(pc2),
`endif
    .err_count(ec2)
  );

  // Reference model state (abstract: position in the table, counters as ints)
  typedef struct {
    bit locked;
    int expect_pos;
    int misses;
    int idx;
    bit err;
    bit ill;
    bit wrap;
    int errc;
    int per;
  } mdl_t;

  int   seq_tbl [7] = '{0, 1, 2, 3, 6, 5, 7};
  mdl_t m1, m2;
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.locked = 0; m.expect_pos = 0; m.misses = 0; m.idx = 0;
    m.err = 0; m.ill = 0; m.wrap = 0; m.errc = 0; m.per = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, bit v, int x, bit clr,
                                    int limit, int cmax);
    int pos;
    m.err = 0; m.ill = 0; m.wrap = 0;
    if (v) begin
      pos = 7;
      for (int k = 0; k < 7; k++) if (seq_tbl[k] == x) pos = k;
      m.idx = pos;
      m.ill = (x == 4);
      if (!m.locked) begin
        if (x == 0) begin
          m.locked = 1; m.expect_pos = 1; m.misses = 0;
        end
      end else if (x == seq_tbl[m.expect_pos]) begin
        m.wrap = (m.expect_pos == 6);
        if (m.wrap && m.per < 65535) m.per++;
        m.expect_pos = (m.expect_pos + 1) % 7;
        m.misses = 0;
      end else begin
        m.err = 1;
        if (m.errc < cmax) m.errc++;
        m.expect_pos = (m.expect_pos + 1) % 7;
        m.misses++;
        if (m.misses == limit) begin
          m.locked = 0; m.misses = 0;
        end
      end
    end
    if (clr) begin
      m.errc = 0; m.per = 0;
    end
    return m;
  endfunction

  task automatic chk(string tag, int obs, int exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all(string who);
    chk({who, "_d1_locked"}, int'(lk1), int'(m1.locked));
    chk({who, "_d1_seq_idx"}, int'(idx1), m1.idx);
    chk({who, "_d1_err_pulse"}, int'(ep1), int'(m1.err));
    chk({who, "_d1_illegal"}, int'(ip1), int'(m1.ill));
    chk({who, "_d1_wrap"}, int'(wp1), int'(m1.wrap));
    chk({who, "_d1_err_count"}, int'(ec1), m1.errc);
    chk({who, "_d2_locked"}, int'(lk2), int'(m2.locked));
    chk({who, "_d2_seq_idx"}, int'(idx2), m2.idx);
    chk({who, "_d2_err_pulse"}, int'(ep2), int'(m2.err));
    chk({who, "_d2_illegal"}, int'(ip2), int'(m2.ill));
    chk({who, "_d2_wrap"}, int'(wp2), int'(m2.wrap));
    chk({who, "_d2_err_count"}, int'(ec2), m2.errc);
`ifdef ARB_SEQ_PERIOD_CNT_EN
    chk({who, "_d1_period"}, int'(pc1), m1.per);
    chk({who, "_d2_period"}, int'(pc2), m2.per);
`endif
  endtask

  // One clocked transaction: drive at negedge, sample 1 ns after posedge
  task automatic step(string who, bit v, int x, bit clr);
    @(negedge clock);
    seq_valid = v;
    seq_in    = 3'(x);
    clr_err   = clr;
    m1 = mdl_step(m1, v, x, clr, 3, 255);
    m2 = mdl_step(m2, v, x, clr, 8, 3);
    @(posedge clock);
    #1;
    n_txn++;
    $display("txn %0d %s v=%0d in=%0d clr=%0d | d1 lk=%0d idx=%0d ep=%0d ip=%0d wp=%0d ec=%0d | d2 lk=%0d ec=%0d",
             n_txn, who, v, x, clr, lk1, idx1, ep1, ip1, wp1, ec1, lk2, ec2);
    chk_all(who);
  endtask

  task automatic period(string who);
    for (int k = 0; k < 7; k++) step(who, 1'b1, seq_tbl[k], 1'b0);
  endtask

  initial begin
    int x;
    bit v, c;

    m1 = mdl_reset();
    m2 = mdl_reset();
    #2;
    chk_all("reset");
    @(negedge clock);
    reset_n = 1'b1;

    // 1: three clean periods
    for (int p = 0; p < 3; p++) period("t1");
    chk("t1_errc_zero", int'(ec1), 0);

    // 2: illegal 4 in the middle of a period, then resume
    step("t2", 1, 0, 0); step("t2", 1, 1, 0); step("t2", 1, 2, 0);
    step("t2", 1, 4, 0);
    chk("t2_idx_illegal", int'(idx1), 7);
    step("t2", 1, 6, 0);
    chk("t2_still_locked", int'(lk1), 1);
    step("t2", 1, 5, 0); step("t2", 1, 7, 0);

    // 3: three consecutive misses drop lock, then hunt ignores non-zero
    step("t3", 1, 0, 0);
    step("t3", 1, 5, 0); step("t3", 1, 5, 0); step("t3", 1, 5, 0);
    chk("t3_unlocked", int'(lk1), 0);
    step("t3", 1, 1, 0); step("t3", 1, 2, 0);
    step("t3", 1, 0, 0);
    chk("t3_relocked", int'(lk1), 1);
    for (int k = 1; k < 7; k++) step("t3", 1, seq_tbl[k], 0);

    // 4: gaps between every sample of a correct period
    for (int k = 0; k < 7; k++) begin
      step("t4gap", 0, $urandom_range(0, 7), 0);
      step("t4", 1, seq_tbl[k], 0);
    end

    // 5: saturation of the narrow counter, then clear with a mismatch
    step("t5", 1, 0, 1);
    for (int k = 0; k < 5; k++) step("t5", 1, 4, 0);
    chk("t5_d2_saturated", int'(ec2), 3);
    step("t5", 1, 4, 1);
    chk("t5_d2_cleared", int'(ec2), 0);

    // Randomised traffic biased toward the expected value
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m1.locked && $urandom_range(0, 9) < 8) x = seq_tbl[m1.expect_pos];
      else if (!m1.locked && $urandom_range(0, 3) == 0) x = 0;
      else x = $urandom_range(0, 7);
      c = ($urandom_range(0, 24) == 0);
      step("rand", v, x, c);
    end

    // 6: asynchronous reset mid-period
    step("t6", 1, 0, 0); step("t6", 1, 1, 0); step("t6", 1, 4, 0);
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    m1 = mdl_reset();
    m2 = mdl_reset();
    #1;
    chk_all("t6_async");
    @(negedge clock);
    reset_n = 1'b1;
    step("t6", 1, 1, 0); step("t6", 1, 2, 0);
    chk("t6_no_relock", int'(lk1), 0);
    step("t6", 1, 0, 0);
    chk("t6_relock", int'(lk1), 1);
    for (int k = 1; k < 7; k++) step("t6", 1, seq_tbl[k], 0);

`ifdef ARB_SEQ_PERIOD_CNT_EN
    step("t7", 1, 0, 1);
    for (int k = 1; k < 7; k++) step("t7", 1, seq_tbl[k], 0);
    period("t7");
    chk("t7_period_two", int'(pc1), 2);
    step("t7", 0, 0, 1);
    chk("t7_period_clr", int'(pc1), 0);
`endif

    @(negedge clock);
    seq_valid = 1'b0;
    clr_err = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
